// File: rtl/term_arb_pkg.sv
// term_arb_pkg: shared types for the terminal write arbiter.
//   term_wr_t   - one text-buffer write {addr, data}
//   arb_state_t - which requester owned the write port last cycle
package term_arb_pkg;
  localparam int TERM_ADDR_W = 12;
  localparam int TERM_DATA_W = 8;

  typedef struct packed {
    logic [TERM_ADDR_W-1:0] addr;
    logic [TERM_DATA_W-1:0] data;
  } term_wr_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CPU  = 2'd1,
    S_DBG  = 2'd2
  } arb_state_t;
endpackage

// File: rtl/term_wr_fifo.sv
// term_wr_fifo: small synchronous FIFO of term_wr_t holding buffered CPU writes.
// Ports:
//   clk, rst        - clock, synchronous active-high reset (clears pointers/count)
//   push, wdata     - enqueue; ignored while full
//   pop, rdata      - dequeue; rdata is the head entry (valid while !empty)
//   full, empty     - status from the registered count
//   count           - number of held entries (0..DEPTH)
module term_wr_fifo
  import term_arb_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  term_wr_t    wdata,
  input  logic        pop,
  output term_wr_t    rdata,
  output logic        full,
  output logic        empty,
  output logic [PW:0] count
);
  term_wr_t      mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;

  assign full    = (count == (PW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  // Storage needs no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  // DEPTH is a power of two, so the pointers wrap on their own.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/term_write_arbiter.sv
// term_write_arbiter: shares the terminal text-buffer write port between
// buffered CPU bus writes and the debugger refresh stream.
// CPU has priority, limited to MAX_CPU_BURST consecutive grants while the
// debugger waits. Output write is registered (latency 1 from grant).
// Ports:
//   clk, rst                       - clock, synchronous active-high reset
//   cpu_we/cpu_addr/cpu_data       - one-cycle CPU write strobe + payload
//   cpu_ready                      - FIFO not full (CPU bus-ready)
//   dbg_valid/dbg_addr/dbg_data    - debugger write request
//   dbg_ready                      - debugger write accepted this cycle
//   terminal_addr/_data/_write     - to the terminal text buffer
//   err_overflow                   - sticky: strobe seen while FIFO full
//   cpu_grant_cnt/dbg_grant_cnt    - grant counters (only with TERM_ARB_STATS_EN)
// Build option: define TERM_ARB_STATS_EN to add the grant counters.
module term_write_arbiter
  import term_arb_pkg::*;
#(
  parameter int FIFO_DEPTH    = 4,
  parameter int MAX_CPU_BURST = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cpu_we,
  input  logic [TERM_ADDR_W-1:0] cpu_addr,
  input  logic [TERM_DATA_W-1:0] cpu_data,
  output logic                   cpu_ready,
  input  logic                   dbg_valid,
  input  logic [TERM_ADDR_W-1:0] dbg_addr,
  input  logic [TERM_DATA_W-1:0] dbg_data,
  output logic                   dbg_ready,
  output logic [TERM_ADDR_W-1:0] terminal_addr,
  output logic                   terminal_write,
  output logic [TERM_DATA_W-1:0] terminal_data,
`ifdef TERM_ARB_STATS_EN
  output logic [15:0]            cpu_grant_cnt,
  output logic [15:0]            dbg_grant_cnt,
`endif
  output logic                   err_overflow
);
  localparam int          PW        = $clog2(FIFO_DEPTH);
  localparam logic [3:0]  BURST_MAX = 4'(MAX_CPU_BURST);

  term_wr_t    fifo_rdata;
  logic        fifo_full, fifo_empty, fifo_pop;
  logic [PW:0] fifo_count;
  logic        grant_cpu, grant_dbg;
  logic [3:0]  burst_cnt;
  arb_state_t  state_q, state_d;

  term_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (cpu_we),
    .wdata ('{addr: cpu_addr, data: cpu_data}),
    .pop   (fifo_pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign cpu_ready = (fifo_count != (PW+1)'(FIFO_DEPTH));

  // Arbitration: CPU wins unless the debugger has waited through a full burst.
  always_comb begin
    grant_cpu = !fifo_empty && (!dbg_valid || (burst_cnt < BURST_MAX));
    grant_dbg = dbg_valid && !grant_cpu;
  end

  // Burst counter only runs while the debugger is actually waiting.
  always_ff @(posedge clk) begin
    if (rst)                         burst_cnt <= '0;
    else if (!dbg_valid || grant_dbg) burst_cnt <= '0;
    else if (grant_cpu && (burst_cnt < BURST_MAX))
                                     burst_cnt <= burst_cnt + 1'b1;
  end

  // State register: records last grant.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = S_IDLE;
    if (grant_cpu)      state_d = S_CPU;
    else if (grant_dbg) state_d = S_DBG;
  end

  always_comb begin
    dbg_ready = grant_dbg;
    fifo_pop  = grant_cpu;
  end

  // state_q is exactly the registered grant, so it doubles as the write strobe.
  assign terminal_write = (state_q != S_IDLE);

  // Address/data hold their last value on idle cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      terminal_addr <= '0;
      terminal_data <= '0;
    end else if (grant_cpu) begin
      terminal_addr <= fifo_rdata.addr;
      terminal_data <= fifo_rdata.data;
    end else if (grant_dbg) begin
      terminal_addr <= dbg_addr;
      terminal_data <= dbg_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                       err_overflow <= 1'b0;
    else if (cpu_we && fifo_full)  err_overflow <= 1'b1;
  end

`ifdef TERM_ARB_STATS_EN
  // Free-running, wrap at 16 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_grant_cnt <= '0;
      dbg_grant_cnt <= '0;
    end else begin
      if (grant_cpu) cpu_grant_cnt <= cpu_grant_cnt + 16'd1;
      if (grant_dbg) dbg_grant_cnt <= dbg_grant_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_term_write_arbiter.sv
// tb_term_write_arbiter: randomized + directed bench with a queue-based
// reference model; expected terminal writes go to a scoreboard queue that a
// separate monitor drains whenever terminal_write is seen.
module tb_term_write_arbiter;
  localparam int DEPTH = 4;
  localparam int MAXB  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_we, dbg_valid;
  logic [11:0] cpu_addr, dbg_addr;
  logic [7:0]  cpu_data, dbg_data;
  logic        cpu_ready, dbg_ready, terminal_write, err_overflow;
  logic [11:0] terminal_addr;
  logic [7:0]  terminal_data;
`ifdef TERM_ARB_STATS_EN
  logic [15:0] cpu_grant_cnt, dbg_grant_cnt;
`endif

  always #5 clk = ~clk;

  term_write_arbiter #(.FIFO_DEPTH(DEPTH), .MAX_CPU_BURST(MAXB)) dut (
    .clk(clk), .rst(rst),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_data(cpu_data), .cpu_ready(cpu_ready),
    .dbg_valid(dbg_valid), .dbg_addr(dbg_addr), .dbg_data(dbg_data), .dbg_ready(dbg_ready),
    .terminal_addr(terminal_addr), .terminal_write(terminal_write), .terminal_data(terminal_data),
`ifdef TERM_ARB_STATS_EN
    .cpu_grant_cnt(cpu_grant_cnt), .dbg_grant_cnt(dbg_grant_cnt),
`endif
    .err_overflow(err_overflow)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Reference model: pending CPU writes, debugger wait streak, sticky overflow.
  logic [19:0] m_q[$];
  logic [19:0] exp_q[$];
  int          m_streak;
  bit          m_ovf;
  int          m_cpu_g, m_dbg_g;

  // One clock of stimulus. Entered and left at posedge+1.
  task automatic step(input bit we, input logic [11:0] a, input logic [7:0] d,
                      input bit dv, input logic [11:0] da, input logic [7:0] dd);
    bit full_before, gc, gd;
    chk("cpu_ready", cpu_ready, (m_q.size() < DEPTH));
    chk("err_overflow", err_overflow, m_ovf);
    cpu_we = we; cpu_addr = a; cpu_data = d;
    dbg_valid = dv; dbg_addr = da; dbg_data = dd;
    #1;
    full_before = (m_q.size() == DEPTH);
    gc = (m_q.size() > 0) && (!dv || m_streak < MAXB);
    gd = dv && !gc;
    chk("dbg_ready", dbg_ready, gd);
    if (gc) begin
      exp_q.push_back(m_q.pop_front());
      m_cpu_g++;
      m_streak = dv ? ((m_streak + 1 > MAXB) ? MAXB : m_streak + 1) : 0;
    end else begin
      if (gd) begin
        exp_q.push_back({da, dd});
        m_dbg_g++;
      end
      m_streak = 0;
    end
    if (we) begin
      if (full_before) m_ovf = 1'b1;
      else             m_q.push_back({a, d});
    end
    @(posedge clk); #1;
    cpu_we = 1'b0; dbg_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
  endtask

  task automatic do_reset();
    rst = 1'b1; cpu_we = 1'b0; dbg_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_q.delete(); m_streak = 0; m_ovf = 1'b0; m_cpu_g = 0; m_dbg_g = 0;
  endtask

  // Monitor: every terminal write must be the next expected one.
  always @(negedge clk) begin
    if (terminal_write === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_write", {terminal_addr, terminal_data}, 32'hDEAD);
      end else begin
        logic [19:0] e;
        e = exp_q.pop_front();
        chk("term_addr", terminal_addr, e[19:8]);
        chk("term_data", terminal_data, e[7:0]);
      end
      if (terminal_data === 8'hEE) chk("dropped_EE_seen", terminal_data, 8'h00);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout");
    $fatal(1);
  end

  initial begin
    logic [7:0] d, dd;
    int n;
    rst = 1'b1; cpu_we = 0; dbg_valid = 0;
    cpu_addr = '0; cpu_data = '0; dbg_addr = '0; dbg_data = '0;
    m_streak = 0; m_ovf = 0; m_cpu_g = 0; m_dbg_g = 0;
    @(posedge clk); @(posedge clk); #1;
    do_reset();
    chk("rst_write", terminal_write, 0);
    chk("rst_addr", terminal_addr, 0);
    chk("rst_data", terminal_data, 0);
    chk("rst_cpu_ready", cpu_ready, 1);
    chk("rst_dbg_ready", dbg_ready, 0);
    chk("rst_ovf", err_overflow, 0);

    // Single CPU write: on the terminal two cycles after the strobe.
    step(1, 12'h123, 8'h41, 0, 12'h0, 8'h0);
    step(0, 12'h0, 8'h0, 0, 12'h0, 8'h0);
    chk("lat_write", terminal_write, 1);
    chk("lat_addr", terminal_addr, 12'h123);
    chk("lat_data", terminal_data, 8'h41);
    idle(3);

    // Fairness: debugger waiting while CPU writes stream in.
    for (int i = 0; i < 8; i++)
      step(1, 12'h200 + 12'(i), 8'h10 + 8'(i), 1, 12'h300 + 12'(i), 8'h80 + 8'(i));
    for (int i = 0; i < 8; i++)
      step(0, 12'h0, 8'h0, 1, 12'h310 + 12'(i), 8'h90 + 8'(i));
    idle(3);

    // Overflow: strobe every cycle with the debugger stealing slots until full.
    n = 0;
    while (m_q.size() < DEPTH && n < 64) begin
      step(1, 12'h400 + 12'(n), 8'(n), 1, 12'h500 + 12'(n), 8'h20);
      n++;
    end
    chk("fill_reached", m_q.size(), DEPTH);
    step(1, 12'h4EE, 8'hEE, 1, 12'h5EE, 8'h21);
    idle(8);
    chk("ovf_sticky", err_overflow, 1);
    do_reset();

    // Debugger only: 256 back-to-back writes.
    for (int i = 0; i < 256; i++) step(0, 12'h0, 8'h0, 1, 12'(i), 8'(i ^ 8'h5A) == 8'hEE ? 8'h00 : 8'(i ^ 8'h5A));
    idle(2);

    // Reset with writes still queued: none may emerge afterwards.
    n = 0;
    while (m_q.size() < 3 && n < 64) begin
      step(1, 12'h600 + 12'(n), 8'h30, 1, 12'h700, 8'h31);
      n++;
    end
    do_reset();
    chk("midrst_write", terminal_write, 0);
    chk("midrst_ready", cpu_ready, 1);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 2000; i++) begin
      d = 8'($urandom); if (d == 8'hEE) d = 8'h00;
      dd = 8'($urandom); if (dd == 8'hEE) dd = 8'h01;
      step(($urandom % 2) == 0, 12'($urandom), d, ($urandom % 4) != 0, 12'($urandom), dd);
    end
    idle(10);
    chk("scoreboard_drained", exp_q.size(), 0);
`ifdef TERM_ARB_STATS_EN
    chk("cpu_grant_cnt", cpu_grant_cnt, 16'(m_cpu_g));
    chk("dbg_grant_cnt", dbg_grant_cnt, 16'(m_dbg_g));
`endif

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
